// File: rtl/triumph_imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// State encoding, default bus widths and burst counter width live here.
package triumph_imem_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOAD  = 2'd1,
    ARB_YIELD = 2'd2
  } arb_state_t;

  typedef logic [BURST_CNT_W-1:0] burst_cnt_t;

endpackage

// File: rtl/triumph_imem_arbiter_if.sv
// Bus bundle between IF fetch path, program loader and the instruction memory.
// The slave modport is the arbiter's view; master is the surrounding system.
interface triumph_imem_arbiter_if
  import triumph_imem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_gnt_o;
  logic              fetch_rvalid_o;
  logic [DATA_W-1:0] fetch_rdata_o;

  logic              load_valid_i;
  logic [ADDR_W-1:0] load_addr_i;
  logic [DATA_W-1:0] load_wdata_i;
  logic              load_ready_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    input  load_valid_i, load_addr_i, load_wdata_i,
    output load_ready_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
    output load_valid_i, load_addr_i, load_wdata_i,
    input  load_ready_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/triumph_burst_cnt.sv
// Counts consecutive loader grants; hit_o flags the grant that reaches the limit.
// Clears on any cycle without an increment and on the hit itself; saturates at all-ones.
module triumph_burst_cnt
  import triumph_imem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       clr_i,
  input  burst_cnt_t limit_i,
  output logic       hit_o
);

  burst_cnt_t r_cnt;
  burst_cnt_t w_cnt_inc;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign hit_o     = inc_i & (w_cnt_inc == limit_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i || hit_o) begin
      r_cnt <= '0;
    end else if (inc_i) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/triumph_imem_arbiter.sv
// Single-port instruction memory arbiter: loader priority with a burst limiter
// that forces one fetch slot. Optional loader lock via TRIUMPH_IMEM_LOCK_EN.
//
// state     | meaning
// ARB_IDLE  | no loader grant in the previous cycle
// ARB_LOAD  | loader burst in progress
// ARB_YIELD | forced fetch slot, exactly one cycle
module triumph_imem_arbiter
  import triumph_imem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef TRIUMPH_IMEM_LOCK_EN
  input  logic load_lock_i,
`endif
  triumph_imem_arbiter_if.slave arb_bus
);

  localparam burst_cnt_t LIMIT = burst_cnt_t'(MAX_BURST);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_fetch_rvalid;
  logic              w_lock;
  logic              w_load_gnt;
  logic              w_fetch_gnt;
  logic              w_cnt_inc;
  logic              w_hit;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_fetch_rdata;

`ifdef TRIUMPH_IMEM_LOCK_EN
  assign w_lock = load_lock_i;
`else
  assign w_lock = 1'b0;
`endif

  // A yield slot already entered is honoured even if the lock rises during it.
  always_comb begin
    w_load_gnt  = 1'b0;
    w_fetch_gnt = 1'b0;
    if (!rst_i) begin
      if (r_state == ARB_YIELD) begin
        w_fetch_gnt = arb_bus.fetch_req_i;
      end else begin
        w_load_gnt  = arb_bus.load_valid_i;
        w_fetch_gnt = arb_bus.fetch_req_i & ~arb_bus.load_valid_i & ~w_lock;
      end
    end
  end

  assign w_cnt_inc = w_load_gnt & ~w_lock;

  triumph_burst_cnt u_burst_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (w_cnt_inc),
    .clr_i   (~w_cnt_inc),
    .limit_i (LIMIT),
    .hit_o   (w_hit)
  );

  always_comb begin
    w_state_nxt = ARB_IDLE;
    if (w_load_gnt) begin
      w_state_nxt = w_hit ? ARB_YIELD : ARB_LOAD;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ARB_IDLE;
      r_fetch_rvalid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_fetch_rvalid <= w_fetch_gnt;
    end
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_load_gnt) begin
      w_mem_addr  = arb_bus.load_addr_i;
      w_mem_wdata = arb_bus.load_wdata_i;
    end else if (w_fetch_gnt) begin
      w_mem_addr  = arb_bus.fetch_addr_i;
    end
  end

  assign w_fetch_rdata = r_fetch_rvalid ? arb_bus.mem_rdata_i : '0;

  assign arb_bus.load_ready_o   = w_load_gnt;
  assign arb_bus.fetch_gnt_o    = w_fetch_gnt;
  assign arb_bus.fetch_rvalid_o = r_fetch_rvalid;
  assign arb_bus.fetch_rdata_o  = w_fetch_rdata;
  assign arb_bus.mem_en_o       = w_load_gnt | w_fetch_gnt;
  assign arb_bus.mem_we_o       = w_load_gnt;
  assign arb_bus.mem_addr_o     = w_mem_addr;
  assign arb_bus.mem_wdata_o    = w_mem_wdata;

endmodule

// File: tb/tb_triumph_imem_arbiter.sv
// Scoreboard bench for triumph_imem_arbiter: stimulus queues expected grants
// and read data, a negedge monitor pops and compares them.
module tb_triumph_imem_arbiter;
  import triumph_imem_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  triumph_imem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus  ();
  triumph_imem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus1 ();

`ifdef TRIUMPH_IMEM_LOCK_EN
  logic load_lock_i;
  logic lock1;
`endif

  triumph_imem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef TRIUMPH_IMEM_LOCK_EN
    .load_lock_i (load_lock_i),
`endif
    .arb_bus     (bus)
  );

  triumph_imem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(1)) dut1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
`ifdef TRIUMPH_IMEM_LOCK_EN
    .load_lock_i (lock1),
`endif
    .arb_bus     (bus1)
  );

  // memory model: unwritten words read back as a fixed pattern
  logic [31:0] mem     [256];
  bit          mem_vld [256];

  function automatic logic [31:0] init_word(logic [7:0] a);
    return (a == 8'h05) ? 32'hDEADBEEF : (32'hA000_0000 | {24'h0, a});
  endfunction

  always @(posedge clk_i) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        mem[bus.mem_addr_o]     <= bus.mem_wdata_o;
        mem_vld[bus.mem_addr_o] <= 1'b1;
      end else begin
        bus.mem_rdata_i <= mem_vld[bus.mem_addr_o] ? mem[bus.mem_addr_o] : init_word(bus.mem_addr_o);
      end
    end
  end
  assign bus1.mem_rdata_i = 32'h0;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int cyc; bit is_load; logic [7:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { int cyc; logic [31:0] data; } rd_t;
  gnt_t gnt_q[$];
  rd_t  rd_q[$];
  gnt_t mon_g;
  rd_t  mon_r;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.load_ready_o && bus.fetch_gnt_o) chk("dual_grant", 64'd1, 64'd0);
      if (bus.load_ready_o || bus.fetch_gnt_o) begin
        if (gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant load=%0b fetch=%0b expected=none (cycle %0d)",
                   bus.load_ready_o, bus.fetch_gnt_o, cyc);
        end else begin
          mon_g = gnt_q.pop_front();
          chk("gnt_cycle", 64'(cyc), 64'(mon_g.cyc));
          chk("gnt_is_load", 64'(bus.load_ready_o), 64'(mon_g.is_load));
          chk("mem_en", 64'(bus.mem_en_o), 64'd1);
          chk("mem_we", 64'(bus.mem_we_o), 64'(mon_g.is_load));
          chk("mem_addr", 64'(bus.mem_addr_o), 64'(mon_g.addr));
          chk("mem_wdata", 64'(bus.mem_wdata_o), mon_g.is_load ? 64'(mon_g.wdata) : 64'd0);
        end
      end else begin
        chk("idle_mem_en", 64'(bus.mem_en_o), 64'd0);
      end
      if (bus.fetch_rvalid_o) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid data=%0h expected=none (cycle %0d)", bus.fetch_rdata_o, cyc);
        end else begin
          mon_r = rd_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("rdata", 64'(bus.fetch_rdata_o), 64'(mon_r.data));
        end
      end else begin
        chk("rdata_gated", 64'(bus.fetch_rdata_o), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(bit lv, logic [7:0] la, logic [31:0] lw, bit fr, logic [7:0] fa);
    bus.load_valid_i = lv;
    bus.load_addr_i  = la;
    bus.load_wdata_i = lw;
    bus.fetch_req_i  = fr;
    bus.fetch_addr_i = fa;
  endtask

  task automatic exp_load(logic [7:0] a, logic [31:0] d);
    gnt_q.push_back('{cyc, 1'b1, a, d});
  endtask

  task automatic exp_fetch(logic [7:0] a, logic [31:0] d);
    gnt_q.push_back('{cyc, 1'b0, a, 32'h0});
    rd_q.push_back('{cyc + 1, d});
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_load_ready"}, 64'(bus.load_ready_o), 64'd0);
    chk({tag, "_fetch_gnt"}, 64'(bus.fetch_gnt_o), 64'd0);
    chk({tag, "_rvalid"}, 64'(bus.fetch_rvalid_o), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.fetch_rdata_o), 64'd0);
    chk({tag, "_mem_en"}, 64'(bus.mem_en_o), 64'd0);
    chk({tag, "_mem_we"}, 64'(bus.mem_we_o), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr_o), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata_o), 64'd0);
  endtask

  // expected kinds per cycle: 1 = load, 0 = fetch
  bit contention_kind [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit brk_lv          [8]  = '{1, 1, 0, 1, 1, 1, 1, 1};
  bit brk_kind        [8]  = '{1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int j;
    rst_i = 1'b0;
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    bus1.load_valid_i = 1'b0;
    bus1.load_addr_i  = 8'h0;
    bus1.load_wdata_i = 32'h0;
    bus1.fetch_req_i  = 1'b0;
    bus1.fetch_addr_i = 8'h0;
`ifdef TRIUMPH_IMEM_LOCK_EN
    load_lock_i = 1'b0;
    lock1       = 1'b0;
`endif
    #2 rst_i = 1'b1;
    tick();
    drive(1'b1, 8'h40, 32'h1, 1'b1, 8'h07);
    #1 chk_all_zero("por");
    tick();

    // reset mid-burst: two loads, then reset with the loader still pending
    rst_i = 1'b0;
    drive(1'b1, 8'h40, 32'h1, 1'b0, 8'h07);
    exp_load(8'h40, 32'h1);
    tick();
    drive(1'b1, 8'h41, 32'h2, 1'b1, 8'h07);
    exp_load(8'h41, 32'h2);
    tick();
    rst_i = 1'b1;
    drive(1'b1, 8'h42, 32'h3, 1'b1, 8'h07);
    #1 chk_all_zero("midburst");
    tick();
    rst_i = 1'b0;
    // after release the counter restarts: four loads before the yield
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h42 + 8'(i), 32'h3 + i, 1'b1, 8'h07);
      if (i < 4) exp_load(8'h42 + 8'(i), 32'h3 + i);
      else       exp_fetch(8'h07, 32'hA000_0007);
      tick();
    end

    // reset right after a fetch grant drops its rvalid
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h08);
    gnt_q.push_back('{cyc, 1'b0, 8'h08, 32'h0});
    tick();
    rst_i = 1'b1;
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    #1 chk_all_zero("rvalid_drop");
    tick();
    rst_i = 1'b0;
    tick();

    // fetch only
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h05);
    exp_fetch(8'h05, 32'hDEADBEEF);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    tick();

    // continuous contention
    j = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h50 + 8'(j), 32'h1000 + j, 1'b1, 8'h07);
      if (contention_kind[i]) begin
        exp_load(8'h50 + 8'(j), 32'h1000 + j);
        j++;
      end else begin
        exp_fetch(8'h07, 32'hA000_0007);
      end
      tick();
    end
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    tick();

    // burst broken by an idle cycle does not yield early
    j = 0;
    for (int i = 0; i < 8; i++) begin
      drive(brk_lv[i], 8'h60 + 8'(j), 32'h2000 + j, 1'b1, 8'h0A);
      if (brk_kind[i]) begin
        exp_load(8'h60 + 8'(j), 32'h2000 + j);
        j++;
      end else begin
        exp_fetch(8'h0A, 32'hA000_000A);
      end
      tick();
    end
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    tick();

    // write then read, and a write right after a fetch returns the old word
    drive(1'b1, 8'h03, 32'h12345678, 1'b0, 8'h0);
    exp_load(8'h03, 32'h12345678);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h03);
    exp_fetch(8'h03, 32'h12345678);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h09);
    exp_fetch(8'h09, 32'hA000_0009);
    tick();
    drive(1'b1, 8'h09, 32'hCAFEF00D, 1'b0, 8'h0);
    exp_load(8'h09, 32'hCAFEF00D);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h09);
    exp_fetch(8'h09, 32'hCAFEF00D);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    tick();

`ifdef TRIUMPH_IMEM_LOCK_EN
    // locked loader: no yield, fetch starved until lock drops
    load_lock_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h70 + 8'(i), 32'h3000 + i, 1'b1, 8'h0B);
      exp_load(8'h70 + 8'(i), 32'h3000 + i);
      tick();
    end
    drive(1'b0, 8'h0, 32'h0, 1'b1, 8'h0B);
    #1 chk("lock_fetch_blocked", 64'(bus.fetch_gnt_o), 64'd0);
    tick();
    load_lock_i = 1'b0;
    exp_fetch(8'h0B, 32'hA000_000B);
    tick();
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0);
    tick();
`endif

    // MAX_BURST=1 alternates loads and fetches
    bus1.load_valid_i = 1'b1;
    bus1.fetch_req_i  = 1'b1;
    bus1.load_addr_i  = 8'h11;
    bus1.fetch_addr_i = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mb1_load_ready", 64'(bus1.load_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("mb1_fetch_gnt", 64'(bus1.fetch_gnt_o), (i % 2 == 0) ? 64'd0 : 64'd1);
      tick();
    end
    bus1.load_valid_i = 1'b0;
    bus1.fetch_req_i  = 1'b0;
    tick();
    tick();

    chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d limit=200000ns", cyc);
    $fatal(1, "timeout");
  end

endmodule
